// File: rtl/rx8b10b_link_ctrl.sv
// Link controller beside an 8b10b receiver: sequences the receiver enable through
// resync/acquire/link and drains the receiver FIFO into a valid/ready byte stream.
module rx8b10b_link_ctrl #(
    parameter int unsigned GOOD_THRESH  = 8,
    parameter int unsigned ERR_THRESH   = 4,
    parameter int unsigned RESYNC_CLKS  = 64,
    parameter int unsigned TIMEOUT_CLKS = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       wordStrobe,
    input  logic       errorDetect,
    input  logic       dataPresent,
    input  logic [7:0] rxData,
    output logic       rxEnable,
    output logic       readStrobe,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       linkUp,
    output logic [1:0] state,
    output logic [7:0] resyncCount
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESYNC  = 2'd1,
        S_ACQUIRE = 2'd2,
        S_LINKED  = 2'd3
    } state_t;

    localparam logic [15:0] RESYNC_LAST  = 16'(RESYNC_CLKS - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]  GOOD_LAST    = 8'(GOOD_THRESH - 1);
    localparam logic [7:0]  ERR_LAST     = 8'(ERR_THRESH - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_timer;
    logic [15:0] w_nextTimer;
    logic [7:0]  r_goodCnt;
    logic [7:0]  w_nextGoodCnt;
    logic [7:0]  r_errCnt;
    logic [7:0]  w_nextErrCnt;
    logic [7:0]  r_resyncCount;
    logic [7:0]  w_nextResyncCount;
    logic        w_forceResync;

    logic        r_rxEnable;
    logic        r_linkUp;
    logic        r_holdoff;
    logic        r_outValid;
    logic [7:0]  r_outData;

    logic        w_goodWord;
    logic        w_badWord;
    logic        w_outFree;
    logic        w_readStrobe;
    logic        w_load;

    assign w_goodWord = wordStrobe && !errorDetect;
    assign w_badWord  = wordStrobe && errorDetect;

    // Dropping enable overrides every other transition and clears the counters.
    always_comb begin
        w_nextState   = r_state;
        w_nextTimer   = r_timer;
        w_nextGoodCnt = r_goodCnt;
        w_nextErrCnt  = r_errCnt;
        w_forceResync = 1'b0;
        if (!enable) begin
            w_nextState   = S_IDLE;
            w_nextTimer   = 16'd0;
            w_nextGoodCnt = 8'd0;
            w_nextErrCnt  = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nextState = S_RESYNC;
                    w_nextTimer = 16'd0;
                end
                S_RESYNC: begin
                    if (r_timer == RESYNC_LAST) begin
                        w_nextState   = S_ACQUIRE;
                        w_nextTimer   = 16'd0;
                        w_nextGoodCnt = 8'd0;
                    end else begin
                        w_nextTimer = r_timer + 16'd1;
                    end
                end
                S_ACQUIRE: begin
                    if (wordStrobe) begin
                        w_nextTimer = 16'd0;
                        if (errorDetect) begin
                            w_nextGoodCnt = 8'd0;
                        end else if (r_goodCnt == GOOD_LAST) begin
                            w_nextState   = S_LINKED;
                            w_nextGoodCnt = 8'd0;
                            w_nextErrCnt  = 8'd0;
                        end else begin
                            w_nextGoodCnt = r_goodCnt + 8'd1;
                        end
                    end else if (r_timer == TIMEOUT_LAST) begin
                        w_nextState   = S_RESYNC;
                        w_nextTimer   = 16'd0;
                        w_forceResync = 1'b1;
                    end else begin
                        w_nextTimer = r_timer + 16'd1;
                    end
                end
                S_LINKED: begin
                    if (w_badWord) begin
                        if (r_errCnt == ERR_LAST) begin
                            w_nextState   = S_RESYNC;
                            w_nextTimer   = 16'd0;
                            w_nextErrCnt  = 8'd0;
                            w_forceResync = 1'b1;
                        end else begin
                            w_nextErrCnt = r_errCnt + 8'd1;
                        end
                    end else if (w_goodWord) begin
                        w_nextErrCnt = 8'd0;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    assign w_nextResyncCount = (w_forceResync && (r_resyncCount != 8'hFF)) ?
                               (r_resyncCount + 8'd1) : r_resyncCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= 16'd0;
            r_goodCnt     <= 8'd0;
            r_errCnt      <= 8'd0;
            r_resyncCount <= 8'd0;
            r_rxEnable    <= 1'b0;
            r_linkUp      <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_timer       <= w_nextTimer;
            r_goodCnt     <= w_nextGoodCnt;
            r_errCnt      <= w_nextErrCnt;
            r_resyncCount <= w_nextResyncCount;
            r_rxEnable    <= (w_nextState == S_ACQUIRE) || (w_nextState == S_LINKED);
            r_linkUp      <= (w_nextState == S_LINKED);
        end
    end

    // The FIFO head lags a pop by one clock, so a pop is always followed by a holdoff.
    assign w_outFree    = !r_outValid || outReady;
    assign w_readStrobe = rst_n && dataPresent && !r_holdoff &&
                          ((r_state != S_LINKED) || w_outFree);
    assign w_load       = w_readStrobe && (r_state == S_LINKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdoff  <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= 8'd0;
        end else begin
            r_holdoff <= w_readStrobe;
            if (w_load) begin
                r_outData  <= rxData;
                r_outValid <= 1'b1;
            end else if (r_outValid && outReady) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign rxEnable    = r_rxEnable;
    assign readStrobe  = w_readStrobe;
    assign outData     = r_outData;
    assign outValid    = r_outValid;
    assign linkUp      = r_linkUp;
    assign state       = r_state;
    assign resyncCount = r_resyncCount;

endmodule

// File: tb/tb_rx8b10b_link_ctrl.sv
// Testbench for rx8b10b_link_ctrl: emulates the receiver FIFO, tracks the link with a
// reference model, and scores forwarded bytes against what was popped while linked.
module tb_rx8b10b_link_ctrl;

    localparam int GOOD_THRESH  = 8;
    localparam int ERR_THRESH   = 4;
    localparam int RESYNC_CLKS  = 64;
    localparam int TIMEOUT_CLKS = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       wordStrobe;
    logic       errorDetect;
    logic       dataPresent;
    logic [7:0] rxData;
    logic       rxEnable;
    logic       readStrobe;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       linkUp;
    logic [1:0] state;
    logic [7:0] resyncCount;

    rx8b10b_link_ctrl #(
        .GOOD_THRESH (GOOD_THRESH),
        .ERR_THRESH  (ERR_THRESH),
        .RESYNC_CLKS (RESYNC_CLKS),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wordStrobe (wordStrobe),
        .errorDetect(errorDetect),
        .dataPresent(dataPresent),
        .rxData     (rxData),
        .rxEnable   (rxEnable),
        .readStrobe (readStrobe),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady),
        .linkUp     (linkUp),
        .state      (state),
        .resyncCount(resyncCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifoQ[$];
    logic [7:0] expQ[$];

    int mState  = 0;
    int mTimer  = 0;
    int mGood   = 0;
    int mErr    = 0;
    int mResync = 0;

    bit popSeen   = 1'b0;
    int readyMode = 0;

    task automatic finishSim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
            if (errors >= 300) finishSim();
        end
    endtask

    // Link rules: one call per clock edge, with the inputs the DUT sampled at that edge.
    task automatic modelStep(input logic en, input logic ws, input logic ed);
        if (!en) begin
            mState = 0; mTimer = 0; mGood = 0; mErr = 0;
        end else begin
            case (mState)
                0: begin mState = 1; mTimer = 0; end
                1: begin
                    if (mTimer == RESYNC_CLKS - 1) begin
                        mState = 2; mTimer = 0; mGood = 0;
                    end else mTimer++;
                end
                2: begin
                    if (ws) begin
                        mTimer = 0;
                        if (ed) mGood = 0;
                        else begin
                            mGood++;
                            if (mGood == GOOD_THRESH) begin mState = 3; mErr = 0; end
                        end
                    end else if (mTimer == TIMEOUT_CLKS - 1) begin
                        mState = 1; mTimer = 0;
                        mResync = (mResync < 255) ? mResync + 1 : 255;
                    end else mTimer++;
                end
                default: begin
                    if (ws && ed) begin
                        mErr++;
                        if (mErr == ERR_THRESH) begin
                            mState = 1; mTimer = 0;
                            mResync = (mResync < 255) ? mResync + 1 : 255;
                        end
                    end else if (ws) mErr = 0;
                end
            endcase
        end
    endtask

    task automatic refreshFifo();
        dataPresent = (fifoQ.size() > 0);
        rxData      = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    endtask

    task automatic applyStimulus(input logic ws, input logic ed, input logic [7:0] data);
        logic [7:0] b;
        @(posedge clk);
        #1;
        if (popSeen && fifoQ.size() > 0) begin
            b = fifoQ.pop_front();
            if (mState == 3) expQ.push_back(b);
        end
        modelStep(enable, wordStrobe, errorDetect);
        wordStrobe  = ws;
        errorDetect = ed;
        if (ws) fifoQ.push_back(data);
        case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = ~outReady;
            default: outReady = 1'($urandom_range(0, 1));
        endcase
        refreshFifo();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic waitModelState(input int target, input logic ws, input int budget);
        int n = 0;
        while (mState != target && n < budget) begin
            applyStimulus(ws, 1'b0, 8'($urandom));
            n++;
        end
        checkOutput("reach_state", 32'(state), 32'(target));
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset",
                    32'({state, linkUp, rxEnable, readStrobe, outValid, outData, resyncCount}), 32'h0);
        mState = 0; mTimer = 0; mGood = 0; mErr = 0; mResync = 0;
        expQ.delete();
        enable = 1'b0; wordStrobe = 1'b0; errorDetect = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    logic [1:0] prevDutState = 2'd0;
    logic       prevStrobe   = 1'b0;
    logic       prevStall    = 1'b0;
    logic [7:0] prevData     = 8'h00;
    int         resyncRun    = 0;

    // Monitor: state/status against the model, pop legality, stall stability, scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            popSeen = 1'b0; prevStrobe = 1'b0; prevStall = 1'b0;
            resyncRun = 0; prevDutState = 2'd0;
        end else begin
            checkOutput("status", 32'({state, linkUp, rxEnable, resyncCount}),
                        32'({mState[1:0], (mState == 3), (mState >= 2), mResync[7:0]}));
            if (readStrobe)
                checkOutput("pop_legal",
                            32'({prevStrobe, dataPresent, (mState == 3) && outValid && !outReady}),
                            32'(3'b010));
            if (prevStall)
                checkOutput("stall_hold", 32'({outValid, outData}), 32'({1'b1, prevData}));
            if (outValid && outReady) begin
                checkOutput("byte_pending", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) checkOutput("byte_value", 32'(outData), 32'(expQ.pop_front()));
            end
            if (state == 2'd1 && !rxEnable) resyncRun++;
            else begin
                if (prevDutState == 2'd1 && state == 2'd2)
                    checkOutput("resync_len", 32'(resyncRun), 32'(RESYNC_CLKS));
                resyncRun = 0;
            end
            prevStrobe   = readStrobe;
            prevStall    = outValid && !outReady;
            prevData     = outData;
            prevDutState = state;
            popSeen      = readStrobe;
        end
    end

    initial begin
        #5_000_000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        finishSim();
    end

    initial begin
        int offCnt   = 0;
        int burstErr = 0;
        int n;
        logic ws;
        logic ed;

        rst_n = 1'b1; enable = 1'b0; wordStrobe = 1'b0; errorDetect = 1'b0;
        outReady = 1'b1; readyMode = 0;
        refreshFifo();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_state",
                    32'({state, linkUp, rxEnable, readStrobe, outValid, outData, resyncCount}), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        enable = 1'b1;

        $display("[TB] bring-up: resync hold then 8 clean words");
        waitModelState(2, 1'b0, 200);
        for (int i = 0; i < GOOD_THRESH; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        checkOutput("linkup_before_last", 32'(linkUp), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("linkup_after_last", 32'(linkUp), 32'd1);
        idleCycles(20);

        $display("[TB] ordered bytes with toggling ready");
        readyMode = 1;
        applyStimulus(1'b1, 1'b0, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h22);
        applyStimulus(1'b1, 1'b0, 8'h33);
        idleCycles(16);
        checkOutput("seq_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] error run e,e,e,g,e,e,e,e");
        readyMode = 2;
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b0, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        checkOutput("linked_before_4th", 32'(state), 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("resync_on_4th", 32'(state), 32'd1);
        checkOutput("resync_count_1", 32'(resyncCount), 32'd1);

        $display("[TB] acquire variant 7 clean, 1 error, 8 clean");
        waitModelState(2, 1'b0, 200);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        checkOutput("variant_not_yet", 32'(linkUp), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("variant_linked", 32'(linkUp), 32'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if (offCnt > 0) begin
                offCnt--;
                enable = (offCnt == 0);
            end else if ($urandom_range(0, 499) == 0) begin
                enable = 1'b0;
                offCnt = $urandom_range(1, 5);
            end
            if ($urandom_range(0, 199) == 0) burstErr = ERR_THRESH;
            ws = ($urandom_range(0, 2) == 0);
            ed = ws && ((burstErr > 0) || ($urandom_range(0, 99) < 15));
            if (ws && burstErr > 0) burstErr--;
            applyStimulus(ws, ed, 8'($urandom));
        end
        enable = 1'b1;
        readyMode = 0;
        n = 0;
        while ((expQ.size() > 0 || outValid) && n < 200) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            n++;
        end
        checkOutput("random_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] asynchronous reset while linked");
        waitModelState(3, 1'b1, 400);
        readyMode = 2;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        doReset();
        enable = 1'b1;

        $display("[TB] stale bytes flushed during acquire");
        readyMode = 0;
        waitModelState(2, 1'b0, 200);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput("acq_no_out", 32'(outValid), 32'd0);
        end
        checkOutput("acq_flushed", 32'(fifoQ.size()), 32'd0);

        $display("[TB] strobe in timeout cycle, then timeout");
        n = 0;
        while (mState == 2 && mTimer < TIMEOUT_CLKS - 2 && n < 100) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            n++;
        end
        applyStimulus(1'b1, 1'b0, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("strobe_beats_timeout", 32'({state, resyncCount}), 32'({2'd2, 8'd0}));
        idleCycles(TIMEOUT_CLKS);
        checkOutput("timeout_fires", 32'({state, rxEnable, resyncCount}), 32'({2'd1, 1'b0, 8'd1}));

        $display("[TB] repeated timeouts to saturation");
        n = 0;
        while (mResync < 255 && n < 40000) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            n++;
        end
        idleCycles(3 * (RESYNC_CLKS + TIMEOUT_CLKS));
        checkOutput("resync_saturated", 32'(resyncCount), 32'd255);

        idleCycles(10);
        checkOutput("final_scoreboard_empty", 32'(expQ.size()), 32'd0);
        checkOutput("final_fifo_empty", 32'(fifoQ.size()), 32'd0);
        finishSim();
    end

endmodule

// File: doc/rx8b10b_link_ctrl.md
Name: rx8b10b_link_ctrl

Overview:
- Link controller sitting beside the 8b10b serial receiver/decoder.
- Sequences the receiver's enable: holds off, then acquires, then declares link-up after a run of clean words.
- Forces a realignment when an errored-word run or an acquisition timeout occurs.
- Drains the receiver FIFO into a valid/ready byte stream, forwarding only while linked and discarding otherwise.

Parameters:
- GOOD_THRESH, 8: consecutive error-free words in ACQUIRE needed to enter LINKED (1..255).
- ERR_THRESH, 4: consecutive errored words in LINKED that force RESYNC (1..255).
- RESYNC_CLKS, 64: clocks rxEnable is held low in RESYNC (2..65535).
- TIMEOUT_CLKS, 4096: clocks in ACQUIRE without any wordStrobe before retrying RESYNC (2..65535).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- enable, input, 1: level; 1 = run link, 0 = return to IDLE.
- wordStrobe, input, 1: 1-clk pulse per decoded word written to the receiver FIFO.
- errorDetect, input, 1: receiver decode error; valid in the cycle wordStrobe is high.
- dataPresent, input, 1: receiver FIFO non-empty.
- rxData, input, 8: receiver FIFO head; first-word-fall-through, valid while dataPresent.
- rxEnable, output, 1: receiver enable.
- readStrobe, output, 1: receiver FIFO pop, 1 clk.
- outData, output, 8: forwarded byte.
- outValid, output, 1: outData valid.
- outReady, input, 1: downstream accepts when outValid && outReady.
- linkUp, output, 1: high only in LINKED.
- state, output, 2: IDLE=0, RESYNC=1, ACQUIRE=2, LINKED=3.
- resyncCount, output, 8: saturating count of forced resyncs (from ACQUIRE timeout or LINKED error run).

Behaviour:
- Reset (rst_n=0, async): state=IDLE; rxEnable=0, readStrobe=0, outValid=0, outData=0, linkUp=0, resyncCount=0; all internal counters=0.
- enable=0 in any state: next state IDLE, counters cleared. Takes priority over every other transition.
- IDLE:
  - rxEnable=0.
  - enable=1 -> RESYNC, timer loaded with 0.
- RESYNC:
  - rxEnable=0; timer increments each clk.
  - timer==RESYNC_CLKS-1 -> ACQUIRE; goodCnt=0, timer=0.
- ACQUIRE:
  - rxEnable=1.
  - wordStrobe && !errorDetect: goodCnt+1.
  - wordStrobe && errorDetect: goodCnt=0.
  - Any wordStrobe clears timer; otherwise timer+1.
  - goodCnt reaching GOOD_THRESH (on the strobe cycle) -> LINKED next clk; errCnt=0.
  - timer==TIMEOUT_CLKS-1 with no strobe -> RESYNC, resyncCount+1 (saturate at 255).
  - A strobe in the timeout cycle wins: clears timer, no resync.
- LINKED:
  - rxEnable=1; linkUp=1.
  - wordStrobe && errorDetect: errCnt+1.
  - wordStrobe && !errorDetect: errCnt=0.
  - errCnt reaching ERR_THRESH -> RESYNC, resyncCount+1 (saturating).
  - No timeout: an idle link (fill words only) produces no strobes.
- linkUp, rxEnable and state are registered; they change the clk after the transition condition.
- FIFO drain:
  - readStrobe is combinationally gated and never asserted in two consecutive clks. The cycle after a pop is a holdoff, because dataPresent/rxData update one clk after a pop.
  - LINKED: readStrobe = dataPresent && !holdoff && (!outValid || outReady). On readStrobe, outData<=rxData and outValid<=1.
  - Otherwise, outValid<=0 when (outValid && outReady).
  - Non-LINKED states: readStrobe = dataPresent && !holdoff. Popped bytes are discarded (outData/outValid untouched), so stale pre-lock bytes are flushed.
  - Errored words in LINKED are still forwarded; downstream correlates via its own policy.
- A byte already in the output register when leaving LINKED stays valid until accepted. No new bytes load until LINKED again.
- Output register obeys valid/ready: outData stable while outValid && !outReady.
- resyncCount never wraps; an IDLE entry via enable=0 does not count.

Test Plan:
- Reset, then enable=1 -> rxEnable=0 for exactly 64 clks, then 1; state=2.
- In ACQUIRE, 8 clean strobes -> linkUp=1 one clk after 8th. Variant: 7 clean, 1 error, 8 clean -> linkUp only after the final 8.
- In LINKED, errors interleaved e,e,e,good,e,e,e,e -> RESYNC only on the 4th consecutive error; resyncCount=1; rxEnable low 64 clks.
- ACQUIRE with no strobes for 4096 clks -> RESYNC, resyncCount increments. Force 300 timeouts -> resyncCount holds 255.
- LINKED, FIFO holding 0x11,0x22,0x33, outReady toggling 1,0,1,... -> outData sequence 0x11,0x22,0x33, no drop or duplicate, readStrobe never on adjacent clks.
- 5 bytes present while ACQUIRE -> all popped, outValid stays 0. Also: rst_n pulse mid-LINKED -> all outputs reset immediately without a clock edge.
